// File: rtl/cook_timer.sv
// Microwave cook-time engine: builds a time from add buttons, counts it down at 1 Hz,
// and handles start/pause, cancel, door interlock and a timed completion flag.
//
// state | meaning
// IDLE  | no time set, T = 0
// SET   | time being entered, not cooking
// RUN   | counting down, heater enabled
// PAUSE | time frozen by start toggle or open door
// DONE  | countdown finished, done held for DONE_CYCLES
module cook_timer #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int SEC_STEP    = 10,
    parameter int DONE_CYCLES = 300_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_sec,
    input  logic       add_min,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_open,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       running,
    output logic       done
);

    localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DCNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DONE_LAST = DCNT_W'(DONE_CYCLES - 1);
    localparam logic [12:0]       T_MAX     = 13'd3599;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [11:0]        t_cur, t_nxt;
    logic [PRE_W-1:0]   pre, pre_nxt;
    logic [DCNT_W-1:0]  dcnt, dcnt_nxt;
    logic               any_add;
    logic               tick;
    logic [12:0]        add_amt;
    logic [12:0]        t_sum;
    logic [12:0]        t_adj;

    assign any_add = add_sec | add_min;
    assign add_amt = (add_sec ? 13'(SEC_STEP) : 13'd0) + (add_min ? 13'd60 : 13'd0);

    // A tick is swallowed by any higher-priority event that leaves RUN this cycle.
    assign tick  = (state == RUN) && (pre == PRE_LAST) && !cancel && !door_open && !start;
    assign t_sum = {1'b0, t_cur} + add_amt - (tick ? 13'd1 : 13'd0);
    assign t_adj = (t_sum > T_MAX) ? T_MAX : t_sum;

    always_comb begin
        state_nxt = state;
        t_nxt     = t_cur;
        if (cancel) begin
            state_nxt = IDLE;
            t_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_add) begin
                        t_nxt     = t_adj[11:0];
                        state_nxt = SET;
                    end
                end
                SET: begin
                    t_nxt = t_adj[11:0];
                    if (start && !door_open && (t_cur != 12'd0))
                        state_nxt = RUN;
                end
                RUN: begin
                    t_nxt = t_adj[11:0];
                    if (door_open || start)
                        state_nxt = PAUSE;
                    else if (tick && (t_adj == 13'd0))
                        state_nxt = DONE;
                end
                PAUSE: begin
                    t_nxt = t_adj[11:0];
                    if (start && !door_open)
                        state_nxt = RUN;
                end
                DONE: begin
                    t_nxt = '0;
                    if (any_add || start || (dcnt == DONE_LAST))
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                end
            endcase
        end
    end

    // Both counters restart from zero on every entry into their state.
    always_comb begin
        pre_nxt  = '0;
        dcnt_nxt = '0;
        if ((state == RUN) && (state_nxt == RUN))
            pre_nxt = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
        if ((state == DONE) && (state_nxt == DONE))
            dcnt_nxt = dcnt + DCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t_cur <= '0;
            pre   <= '0;
            dcnt  <= '0;
            sec   <= '0;
            min   <= '0;
        end else begin
            state <= state_nxt;
            t_cur <= t_nxt;
            pre   <= pre_nxt;
            dcnt  <= dcnt_nxt;
            sec   <= 6'(t_nxt % 12'd60);
            min   <= 6'(t_nxt / 12'd60);
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
